// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared constants and state encoding for the LCD frame path
//
// Purpose: frame geometry, blank character and scheduler state enum, shared by
// the frame scheduler and the display control unit.
// Ports: none (package).
package lcd_pkg;

  localparam int         LCD_FRAME_LEN = 32;
  localparam int         LCD_IDX_W     = 5;
  localparam logic [7:0] LCD_BLANK     = 8'h20;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    PENDING,
    DWELL
  } lcd_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick
//
// Purpose: returns the first set request strictly after the last winner,
// wrapping around; one-hot result, all-zero when nothing is requested.
// Ports:
//   req  in  NREQ           request vector
//   last in  $clog2(NREQ)   index of the previous winner
//   pick out NREQ           one-hot winner
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last,
  output logic [NREQ-1:0]         pick
);

  localparam int LW = $clog2(NREQ);

  int            w_idx;
  logic [LW-1:0] w_sel;
  logic          w_found;

  // Scan last+1 .. last+NREQ so the previous winner is checked last.
  always_comb begin
    pick    = '0;
    w_idx   = 0;
    w_sel   = '0;
    w_found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = (int'(last) + k) % NREQ;
      w_sel = LW'(w_idx);
      if (!w_found && req[w_sel]) begin
        pick[w_sel] = 1'b1;
        w_found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lcd_frame_scheduler.sv
// rtl/lcd_frame_scheduler.sv - double-buffered 16x2 LCD frame sharing between requesters
//
// Purpose: grants one requester at a time to stream a 32-byte frame into the
// shadow buffer, flips shadow/active at a display frame boundary and then holds
// the frame for DWELL_TICKS cycles before arbitrating again.
// Ports:
//   clock500Hz  in   1        clock
//   reset_n     in   1        async active-low reset
//   req         in   NREQ     frame request per requester (level)
//   wr_valid    in   NREQ     byte valid per requester
//   wr_data     in   NREQ*8   byte per requester, requester i at [8*i+7:8*i]
//   gnt         out  NREQ     registered one-hot grant
//   wr_ready    out  NREQ     gnt while loading
//   char_index  in   5        character position read by the display unit
//   phrase      out  8        active buffer character at char_index
//   busy        out  1        scheduler not idle
//   frame_swap  out  1        pulse on the cycle the active buffer flips
module lcd_frame_scheduler
  import lcd_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int DWELL_TICKS = 1000
) (
  input  logic                 clock500Hz,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      wr_valid,
  input  logic [NREQ*8-1:0]    wr_data,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      wr_ready,
  input  logic [LCD_IDX_W-1:0] char_index,
  output logic [7:0]           phrase,
  output logic                 busy,
  output logic                 frame_swap
);

  localparam int                   LW       = $clog2(NREQ);
  localparam int                   DW       = $clog2(DWELL_TICKS + 1);
  localparam logic [LCD_IDX_W-1:0] LAST_PTR = LCD_IDX_W'(LCD_FRAME_LEN - 1);

  lcd_state_e           r_state;
  lcd_state_e           w_next;
  logic [NREQ-1:0]      r_gnt;
  logic [LW-1:0]        r_rr_last;
  logic [LCD_IDX_W-1:0] r_wptr;
  logic [DW-1:0]        r_dwell;
  logic                 r_sel;
  logic [LCD_IDX_W-1:0] r_idx_q;
  logic [7:0]           r_buf0 [LCD_FRAME_LEN];
  logic [7:0]           r_buf1 [LCD_FRAME_LEN];

  logic [NREQ-1:0]      w_pick;
  logic [LW-1:0]        w_pick_idx;
  logic [LW-1:0]        w_g_idx;
  logic                 w_g_req;
  logic                 w_accept;
  logic                 w_take;
  logic [7:0]           w_data;
  logic                 w_boundary;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req  (req),
    .last (r_rr_last),
    .pick (w_pick)
  );

  always_comb begin
    w_pick_idx = '0;
    w_g_idx    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_pick[i]) w_pick_idx = LW'(i);
      if (r_gnt[i])  w_g_idx    = LW'(i);
    end
  end

  assign gnt        = r_gnt;
  assign wr_ready   = (r_state == LOAD) ? r_gnt : '0;
  assign w_g_req    = |(req & r_gnt);
  assign w_accept   = |(wr_valid & wr_ready);
  // A dropped request wins over a byte offered on the same cycle.
  assign w_take     = (r_state == LOAD) && w_g_req && w_accept;
  assign w_data     = wr_data[{w_g_idx, 3'b000} +: 8];
  // Display has wrapped back to the first character: start of a new refresh pass.
  assign w_boundary = (char_index == '0) && (r_idx_q != '0);
  assign frame_swap = (r_state == PENDING) && w_boundary;
  assign busy       = (r_state != IDLE);
  assign phrase     = r_sel ? r_buf1[char_index] : r_buf0[char_index];

  always_ff @(posedge clock500Hz or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (|req) w_next = LOAD;
      LOAD: begin
        if (!w_g_req)                         w_next = IDLE;
        else if (w_accept && r_wptr == LAST_PTR) w_next = PENDING;
      end
      PENDING: if (w_boundary) w_next = DWELL;
      DWELL:   if (r_dwell == '0) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock500Hz or negedge reset_n) begin
    if (!reset_n) begin
      r_gnt     <= '0;
      r_rr_last <= LW'(NREQ - 1);
      r_wptr    <= '0;
      r_dwell   <= '0;
      r_sel     <= 1'b0;
      r_idx_q   <= '0;
    end else begin
      r_idx_q <= char_index;
      case (r_state)
        IDLE: begin
          if (|req) begin
            r_gnt     <= w_pick;
            r_rr_last <= w_pick_idx;
            r_wptr    <= '0;
          end
        end
        LOAD: begin
          if (!w_g_req) begin
            r_gnt  <= '0;
            r_wptr <= '0;
          end else if (w_accept) begin
            if (r_wptr == LAST_PTR) begin
              r_gnt  <= '0;
              r_wptr <= '0;
            end else begin
              r_wptr <= r_wptr + 1'b1;
            end
          end
        end
        PENDING: begin
          if (w_boundary) begin
            r_sel   <= ~r_sel;
            r_dwell <= DW'(DWELL_TICKS - 1);
          end
        end
        DWELL: begin
          if (r_dwell != '0) r_dwell <= r_dwell - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Bytes always land in the buffer not currently on display.
  always_ff @(posedge clock500Hz or negedge reset_n) begin
    if (!reset_n) begin
      r_buf0 <= '{default: LCD_BLANK};
      r_buf1 <= '{default: LCD_BLANK};
    end else if (w_take) begin
      if (r_sel) r_buf0[r_wptr] <= w_data;
      else       r_buf1[r_wptr] <= w_data;
    end
  end

endmodule

// File: tb/tb_lcd_frame_scheduler.sv
// tb/tb_lcd_frame_scheduler.sv - directed self-checking bench for lcd_frame_scheduler
module tb_lcd_frame_scheduler;

  logic        clock500Hz;
  logic        reset_n;
  logic [1:0]  req;
  logic [1:0]  wr_valid;
  logic [15:0] wr_data;
  logic [1:0]  gnt;
  logic [1:0]  wr_ready;
  logic [4:0]  char_index;
  logic [7:0]  phrase;
  logic        busy;
  logic        frame_swap;

  int          n_vec;
  int          n_err;
  int          cyc;
  int          swap_cyc;
  int          acc;
  int          acc2;
  logic [7:0]  frame [32];

  lcd_frame_scheduler #(.NREQ(2), .DWELL_TICKS(4)) dut (
    .clock500Hz (clock500Hz),
    .reset_n    (reset_n),
    .req        (req),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .gnt        (gnt),
    .wr_ready   (wr_ready),
    .char_index (char_index),
    .phrase     (phrase),
    .busy       (busy),
    .frame_swap (frame_swap)
  );

  initial begin
    clock500Hz = 1'b0;
    forever #5 clock500Hz = ~clock500Hz;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock500Hz);
    #1;
    cyc++;
  endtask

  task automatic fill(input logic [7:0] base);
    for (int k = 0; k < 32; k++) frame[k] = base + 8'(k);
  endtask

  task automatic stream(input int r, input int first, input int n, output int cnt);
    cnt = 0;
    for (int k = first; k < first + n; k++) begin
      wr_valid           = 2'b11;
      wr_data[8*r +: 8]     = frame[k];
      wr_data[8*(1-r) +: 8] = 8'hEE;
      #1;
      if (wr_ready[r]) cnt++;
      tick();
    end
    wr_valid = '0;
  endtask

  task automatic wait_gnt();
    int n;
    n = 0;
    while (gnt == 2'b00 && n < 64) begin
      tick();
      n++;
    end
    check("grant_seen", {31'b0, |gnt}, 32'd1);
  endtask

  task automatic do_swap(input string tag, input logic [7:0] exp0);
    char_index = 5'd1;
    tick();
    char_index = 5'd0;
    #1;
    check({tag, "_swap_pulse"}, frame_swap, 1);
    tick();
    swap_cyc = cyc;
    check({tag, "_phrase0"}, phrase, exp0);
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    req        = '0;
    wr_valid   = '0;
    wr_data    = '0;
    char_index = '0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    cyc   = 0;
    swap_cyc = 0;

    // Reset state: blank display, no grant.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      char_index = 5'(i);
      #1;
      check("reset_blank", phrase, 8'h20);
    end
    check("reset_gnt", gnt, 0);
    check("reset_busy", busy, 0);
    check("reset_wr_ready", wr_ready, 0);
    check("reset_swap", frame_swap, 0);

    // Single "HELLO" frame from requester 0, swap on a 5->0 wrap.
    char_index = 5'd5;
    req = 2'b01;
    wait_gnt();
    check("hello_gnt", gnt, 2'b01);
    fill(8'h41);
    frame[0] = 8'h48; frame[1] = 8'h45; frame[2] = 8'h4C; frame[3] = 8'h4C; frame[4] = 8'h4F;
    stream(0, 0, 32, acc);
    check("hello_accepts", acc, 32);
    check("hello_gnt_off", gnt, 0);
    check("hello_busy", busy, 1);
    req = 2'b00;
    tick();
    check("hello_no_early_swap", frame_swap, 0);
    char_index = 5'd0;
    #1;
    check("hello_swap_pulse", frame_swap, 1);
    check("hello_pre_swap", phrase, 8'h20);
    tick();
    check("hello_phrase0", phrase, 8'h48);
    check("hello_swap_once", frame_swap, 0);
    char_index = 5'd4;
    #1;
    check("hello_phrase4", phrase, 8'h4F);
    char_index = 5'd31;
    #1;
    check("hello_phrase31", phrase, 8'h60);
    char_index = 5'd0;
    #1;
    tick(); tick(); tick();
    check("dwell_busy", busy, 1);
    tick();
    check("dwell_done", busy, 0);

    // Both requesting: grants alternate 0,1,0,1 with a 5-cycle gap after each swap.
    do_reset();
    req = 2'b11;
    wait_gnt();
    check("rr_first", gnt, 2'b01);
    fill(8'h30);
    stream(0, 0, 32, acc);
    check("rr_acc0", acc, 32);
    do_swap("rr0", 8'h30);
    wait_gnt();
    check("rr_gap1", cyc - swap_cyc, 5);
    check("rr_second", gnt, 2'b10);
    fill(8'h60);
    stream(1, 0, 32, acc);
    check("rr_acc1", acc, 32);
    do_swap("rr1", 8'h60);
    char_index = 5'd31;
    #1;
    check("rr1_phrase31", phrase, 8'h7F);
    char_index = 5'd0;
    #1;
    wait_gnt();
    check("rr_gap2", cyc - swap_cyc, 5);
    check("rr_third", gnt, 2'b01);
    fill(8'h90);
    stream(0, 0, 32, acc);
    do_swap("rr2", 8'h90);
    wait_gnt();
    check("rr_fourth", gnt, 2'b10);

    // Requester 1 gives up after 10 bytes: abort, display untouched, 0 wins next.
    fill(8'hA0);
    stream(1, 0, 10, acc);
    check("abort_acc", acc, 10);
    req = 2'b01;
    tick();
    check("abort_gnt", gnt, 0);
    check("abort_busy", busy, 0);
    check("abort_swap", frame_swap, 0);
    check("abort_phrase", phrase, 8'h90);
    tick();
    check("abort_next_gnt", gnt, 2'b01);

    // Last byte lands on a 7->0 wrap, then index parked at 0: must stay pending.
    fill(8'hC0);
    char_index = 5'd7;
    stream(0, 0, 31, acc);
    char_index = 5'd0;
    stream(0, 31, 1, acc2);
    check("park_acc", acc + acc2, 32);
    req = 2'b00;
    for (int i = 0; i < 3; i++) begin
      check("park_no_swap", frame_swap, 0);
      tick();
    end
    check("park_busy", busy, 1);
    check("park_phrase", phrase, 8'h90);
    char_index = 5'd7;
    #1;
    check("park_nonzero", frame_swap, 0);
    tick();
    char_index = 5'd0;
    #1;
    check("park_swap_pulse", frame_swap, 1);
    tick();
    check("park_phrase0", phrase, 8'hC0);
    char_index = 5'd31;
    #1;
    check("park_phrase31", phrase, 8'hDF);
    char_index = 5'd0;
    tick(); tick(); tick(); tick(); tick();

    // Reset dropped in the middle of a load.
    req = 2'b01;
    wait_gnt();
    check("mid_gnt", gnt, 2'b01);
    fill(8'hE0);
    stream(0, 0, 17, acc);
    check("mid_acc", acc, 17);
    wr_valid = 2'b01;
    wr_data[7:0] = frame[17];
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_gnt", gnt, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_wr_ready", wr_ready, 0);
    check("mid_rst_wptr", dut.r_wptr, 0);
    for (int i = 0; i < 32; i++) begin
      char_index = 5'(i);
      #1;
      check("mid_rst_blank", phrase, 8'h20);
    end
    wr_valid = '0;
    req = '0;
    tick();
    reset_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
